// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the core's memory stage
// (master) and the data-memory responder (slave).
//
// Handshake: the master raises `request` with a stable payload (we_re, mask,
// address, store_data) and keeps all of it stable until the slave pulses
// `valid` for one cycle. `load_data` and `err` are meaningful in that cycle.
// The master drops `request` in the cycle after `valid` unless it wants
// another transaction; a request still high then is taken as a new one.
//
// Signals:
//   request     master->slave  transaction request
//   we_re       master->slave  1 = store, 0 = load
//   mask[3:0]   master->slave  store byte-lane enables
//   address     master->slave  byte address
//   store_data  master->slave  store write data
//   valid       slave->master  one-cycle completion pulse
//   load_data   slave->master  load word (holds between loads)
//   err         slave->master  range error, only with valid
interface data_mem_if;
  logic        request;
  logic        we_re;
  logic [3:0]  mask;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        valid;
  logic [31:0] load_data;
  logic        err;

  modport master (
    output request, we_re, mask, address, store_data,
    input  valid, load_data, err
  );

  modport slave (
    input  request, we_re, mask, address, store_data,
    output valid, load_data, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: data RAM behind the core's data-memory interface.
// Each request is held for LATENCY cycles. After that the store is committed
// or the full load word is registered, and `valid` pulses for one cycle.
//
// Parameters:
//   ADDR_WIDTH  word-index bits, depth = 2**ADDR_WIDTH 32-bit words
//   LATENCY     cycles from acceptance to valid, 1..15
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        data_mem_if.slave (request/payload in, valid/load_data/err out)
//   fsm_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP) for observation
// Optional feature:
//   MEM_RANGE_CHECK_EN  when defined, a nonzero address above the array depth
//                       raises err, suppresses the store and returns 0 on
//                       load_data. Otherwise upper bits are ignored (aliasing)
//                       and err is always 0.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_if.slave        bus,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept;
  logic        enter_resp;

  logic        cap_we;
  logic [3:0]  cap_mask;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;

  logic        acc_we;
  logic [3:0]  acc_mask;
  logic [31:0] acc_addr;
  logic [31:0] acc_data;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic        range_err;
  logic        addr_unused;

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];
  logic [31:0] load_q;
  logic        err_q;

  // Next-state logic. With LATENCY==1 the array access happens on the
  // accepting edge itself, so WAIT is skipped.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.request) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The payload is captured only for the WAIT path. When the access happens
  // on the accepting edge (LATENCY==1), the live bus is used instead.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      cap_we   <= bus.we_re;
      cap_mask <= bus.mask;
      cap_addr <= bus.address;
      cap_data <= bus.store_data;
    end
  end

  always_comb begin
    if (state == IDLE) begin
      acc_we   = bus.we_re;
      acc_mask = bus.mask;
      acc_addr = bus.address;
      acc_data = bus.store_data;
    end else begin
      acc_we   = cap_we;
      acc_mask = cap_mask;
      acc_addr = cap_addr;
      acc_data = cap_data;
    end
  end

  assign acc_idx = acc_addr[ADDR_WIDTH+1:2];

`ifdef MEM_RANGE_CHECK_EN
  assign range_err   = |acc_addr[31:ADDR_WIDTH+2];
  assign addr_unused = ^acc_addr[1:0];
`else
  assign range_err   = 1'b0;
  assign addr_unused = ^{acc_addr[31:ADDR_WIDTH+2], acc_addr[1:0]};
`endif

  // Store commit. rst blocks the write, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && !range_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
      end
    end
  end

  // load_data only changes on a completing load or a range error.
  // err_q is sampled on the same edge and qualified by RESP on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q <= 32'd0;
      err_q  <= 1'b0;
    end else if (enter_resp) begin
      err_q <= range_err;
      if (range_err)   load_q <= 32'd0;
      else if (!acc_we) load_q <= mem[acc_idx];
    end
  end

  assign bus.valid     = (state == RESP);
  assign bus.err       = err_q & (state == RESP);
  assign bus.load_data = load_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. Three instances run side by side:
// LATENCY 2, 1 and 4, all with ADDR_WIDTH 10. Driver tasks issue directed
// transactions and push the expected response, tagged with its instance and
// completion cycle, into exp_q. A negedge monitor pops an entry for every
// valid pulse and compares against it.
module tb_data_mem_responder;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] cyc;
    logic        err;
    logic        chk_ld;
    logic [31:0] ld;
  } exp_t;

`ifdef MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT hookup ----------------
  logic        req  [3];
  logic        we   [3];
  logic [3:0]  msk  [3];
  logic [31:0] adr  [3];
  logic [31:0] sdat [3];
  logic        vld  [3];
  logic        er   [3];
  logic [31:0] ld   [3];
  logic [1:0]  st   [3];

  data_mem_if bus0 ();
  data_mem_if bus1 ();
  data_mem_if bus2 ();

  assign bus0.request = req[0]; assign bus0.we_re = we[0]; assign bus0.mask = msk[0];
  assign bus0.address = adr[0]; assign bus0.store_data = sdat[0];
  assign bus1.request = req[1]; assign bus1.we_re = we[1]; assign bus1.mask = msk[1];
  assign bus1.address = adr[1]; assign bus1.store_data = sdat[1];
  assign bus2.request = req[2]; assign bus2.we_re = we[2]; assign bus2.mask = msk[2];
  assign bus2.address = adr[2]; assign bus2.store_data = sdat[2];

  assign vld[0] = bus0.valid; assign er[0] = bus0.err; assign ld[0] = bus0.load_data;
  assign vld[1] = bus1.valid; assign er[1] = bus1.err; assign ld[1] = bus1.load_data;
  assign vld[2] = bus2.valid; assign er[2] = bus2.err; assign ld[2] = bus2.load_data;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .fsm_state(st[0]));
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .fsm_state(st[1]));
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .fsm_state(st[2]));

  // ---------------- scoreboard state ----------------
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_ld [3];
  bit          held    [3];
  int          lat     [3];

  // ---------------- driver ----------------
  // Called at a negedge. Returns at a negedge once valid has been seen.
  // With keep=0 the request is dropped and one extra cycle passes, so the
  // instance is IDLE at the next call. With keep=1 the request stays high
  // and the next call only changes the payload.
  task automatic txn(input int id, input logic w, input logic [3:0] m,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_ld, input logic exp_err,
                     input logic chk, input bit keep);
    exp_t e;
    int   n;
    req[id] = 1'b1; we[id] = w; msk[id] = m; adr[id] = a; sdat[id] = d;
    e.id     = 2'(id);
    e.cyc    = 32'(cyc + lat[id] + (held[id] ? 1 : 0));
    e.err    = exp_err;
    e.chk_ld = chk;
    if (exp_err) begin
      e.ld = 32'd0;
      last_ld[id] = 32'd0;
    end else if (w) begin
      e.ld = last_ld[id];
    end else begin
      e.ld = exp_ld;
      last_ld[id] = exp_ld;
    end
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (vld[id] !== 1'b1 && n < 40);
    if (vld[id] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d addr=%h: no valid within 40 cycles", id, a);
      void'(exp_q.pop_back());
    end
    held[id] = keep;
    if (!keep) begin
      req[id] = 1'b0;
      @(negedge clk);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (vld[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_valid dut%0d cycle=%0d: got valid, expected none", i, cyc);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (int'(e.id) != i || e.cyc != 32'(cyc)) begin
            errors++;
            $display("FAIL valid_timing got dut%0d cycle %0d, expected dut%0d cycle %0d",
                     i, cyc, e.id, e.cyc);
          end
          checks++;
          if (er[i] !== e.err) begin
            errors++;
            $display("FAIL err dut%0d cycle=%0d got %b expected %b", i, cyc, er[i], e.err);
          end
          if (e.chk_ld) begin
            checks++;
            if (ld[i] !== e.ld) begin
              errors++;
              $display("FAIL load_data dut%0d cycle=%0d got %h expected %h", i, cyc, ld[i], e.ld);
            end
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    lat[0] = 2; lat[1] = 1; lat[2] = 4;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; msk[i] = 4'h0; adr[i] = 32'd0; sdat[i] = 32'd0;
      last_ld[i] = 32'd0; held[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values of every instance.
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vld[i] !== 1'b0) begin errors++; $display("FAIL reset_valid dut%0d got %b expected 0", i, vld[i]); end
      checks++;
      if (er[i] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d got %b expected 0", i, er[i]); end
      checks++;
      if (ld[i] !== 32'd0) begin errors++; $display("FAIL reset_load_data dut%0d got %h expected 0", i, ld[i]); end
    end
    rst = 1'b0;

    // LATENCY=2: store/load round trip, issued in the first cycle out of reset.
    txn(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    // Byte offset in address[1:0] is ignored; mask is ignored on loads.
    txn(0, 1'b0, 4'h0, 32'h103, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    // Byte lanes.
    txn(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 1'b0, 1'b1, 1'b0);
    txn(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 1'b0, 1'b1, 1'b0);
    // Range check versus aliasing at 0x1000 (word 0 modulo the depth).
    txn(0, 1'b1, 4'hF, 32'h0, 32'h0BADCAFE, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(0, 1'b1, 4'hF, 32'h1000, 32'h13572468, 32'h0, RC, 1'b0, 1'b0);
    txn(0, 1'b0, 4'hF, 32'h0, 32'h0, RC ? 32'h0BADCAFE : 32'h13572468, 1'b0, 1'b1, 1'b0);
    txn(0, 1'b0, 4'hF, 32'h1000, 32'h0, RC ? 32'h0 : 32'h13572468, RC, 1'b1, 1'b0);

    // LATENCY=1: request held high across alternating loads.
    txn(1, 1'b1, 4'hF, 32'h8, 32'h0A0A0A0A, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(1, 1'b1, 4'hF, 32'hC, 32'h0B0B0B0B, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(1, 1'b0, 4'hF, 32'h8, 32'h0, 32'h0A0A0A0A, 1'b0, 1'b1, 1'b1);
    txn(1, 1'b0, 4'hF, 32'hC, 32'h0, 32'h0B0B0B0B, 1'b0, 1'b1, 1'b1);
    txn(1, 1'b0, 4'hF, 32'h8, 32'h0, 32'h0A0A0A0A, 1'b0, 1'b1, 1'b1);
    txn(1, 1'b0, 4'hF, 32'hC, 32'h0, 32'h0B0B0B0B, 1'b0, 1'b1, 1'b0);

    // LATENCY=4: a store aborted by reset must not land or pulse valid.
    txn(2, 1'b1, 4'hF, 32'h40, 32'h01234567, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'h01234567, 1'b0, 1'b1, 1'b0);
    req[2] = 1'b1; we[2] = 1'b1; msk[2] = 4'hF; adr[2] = 32'h40; sdat[2] = 32'hCAFEF00D;
    @(negedge clk);          // accepted on the edge just passed
    @(negedge clk);
    rst = 1'b1;
    req[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      last_ld[i] = 32'd0;
      held[i] = 1'b0;
    end
    checks++;
    if (ld[2] !== 32'd0) begin errors++; $display("FAIL midreset_load_data got %h expected 0", ld[2]); end
    repeat (6) @(negedge clk);
    txn(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'h01234567, 1'b0, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
